// File: rtl/usb_pkg.sv
// Shared USB transmit types and constants. DATA1 support is compiled in only when
// USB_TX_DATA1_EN is defined.
package usb_pkg;

    typedef enum logic [2:0] {
        TxNone  = 3'd0,
        TxData0 = 3'd1,
        TxAck   = 3'd2,
        TxNak   = 3'd3,
        TxStall = 3'd4,
        TxData1 = 3'd5
    } tx_packet_t;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StPid,
        StData,
        StCrcLo,
        StCrcHi,
        StEopSe0,
        StEopJ
    } tx_state_t;

    localparam logic [7:0]  PID_DATA0  = 8'hC3;
    localparam logic [7:0]  PID_DATA1  = 8'h4B;
    localparam logic [7:0]  PID_ACK    = 8'hD2;
    localparam logic [7:0]  PID_NAK    = 8'h5A;
    localparam logic [7:0]  PID_STALL  = 8'h1E;
    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [7:0] pid_byte(input tx_packet_t pkt);
        logic [7:0] pid;
        case (pkt)
            TxAck:   pid = PID_ACK;
            TxNak:   pid = PID_NAK;
            TxStall: pid = PID_STALL;
`ifdef USB_TX_DATA1_EN
            TxData1: pid = PID_DATA1;
`endif
            default: pid = PID_DATA0;
        endcase
        return pid;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 (poly 0x8005, init 0xFFFF), one message bit per enabled cycle.
// Kept standalone so the receive-side checker can reuse it.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;
    logic        feedback;

    always_comb begin
        feedback = din ^ crc_q[15];
        crc_d    = crc_q;
        if (clear) begin
            crc_d = CRC16_INIT;
        end else if (enable) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, PID, payload, CRC16 and EOP with bit stuffing
// and NRZI. Define USB_TX_DATA1_EN to accept tx_packet=5 (DATA1).
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occ,
    input  logic [7:0] tx_data,
    output logic       get_tx_data,
    output logic       dp_out,
    output logic       dm_out,
    output logic       tx_transfer_active
);

    localparam int unsigned BcW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CntW = $clog2(MAX_PAYLOAD + 1);
    localparam logic [BcW-1:0]  BitLast = BcW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_PAYLOAD);

    tx_state_t       state_q, state_d;
    tx_packet_t      pkt_q, pkt_d;
    logic [BcW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [2:0]      ones_q, ones_d;
    logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
    logic            line_q, line_d;
    logic            dp_q, dp_d;
    logic            dm_q, dm_d;
    logic            pop_q, pop_d;
    logic            active_q, active_d;

    logic            crc_clear, crc_en, crc_din;
    logic [15:0]     crc;
    logic            accept_ok, is_data, emit, tx_bit, send_se0;

    usb_crc16 u_crc (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (crc_clear),
        .enable (crc_en),
        .din    (crc_din),
        .crc    (crc)
    );

    always_comb begin
        case (tx_packet)
            TxData0, TxAck, TxNak, TxStall: accept_ok = 1'b1;
`ifdef USB_TX_DATA1_EN
            TxData1:                        accept_ok = 1'b1;
`endif
            default:                        accept_ok = 1'b0;
        endcase
    end

`ifdef USB_TX_DATA1_EN
    assign is_data = (pkt_q == TxData0) || (pkt_q == TxData1);
`else
    assign is_data = (pkt_q == TxData0);
`endif

    always_comb begin
        state_d    = state_q;
        pkt_d      = pkt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        ones_d     = ones_q;
        byte_cnt_d = byte_cnt_q;
        line_d     = line_q;
        dp_d       = dp_q;
        dm_d       = dm_q;
        pop_d      = 1'b0;
        active_d   = active_q;
        crc_clear  = 1'b0;
        crc_en     = 1'b0;
        crc_din    = 1'b0;
        emit       = 1'b0;
        tx_bit     = 1'b0;
        send_se0   = 1'b0;

        // The accepting edge already drives the first SYNC bit.
        if (state_q == StIdle) begin
            bit_cnt_d = '0;
            if (accept_ok) begin
                pkt_d      = tx_packet_t'(tx_packet);
                state_d    = StSync;
                shift_d    = SYNC_BYTE;
                bit_idx_d  = 4'd0;
                ones_d     = 3'd0;
                byte_cnt_d = '0;
                line_d     = 1'b1;
                active_d   = 1'b1;
                crc_clear  = 1'b1;
                emit       = 1'b1;
            end
        end else if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            emit      = 1'b1;
        end else begin
            bit_cnt_d = bit_cnt_q + BcW'(1);
        end

        if (emit) begin
            case (state_d)
                StEopSe0: begin
                    if (bit_idx_d == 4'd2) begin
                        state_d = StEopJ;
                        line_d  = 1'b1;
                        dp_d    = 1'b1;
                        dm_d    = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_d + 4'd1;
                    end
                end
                StEopJ: begin
                    state_d  = StIdle;
                    active_d = 1'b0;
                end
                default: begin
                    // A pending stuff bit goes out before any field change, so the shifter stalls.
                    if (ones_d == 3'd6) begin
                        ones_d = 3'd0;
                    end else begin
                        if (bit_idx_d == 4'd8) begin
                            case (state_d)
                                StSync: begin
                                    state_d   = StPid;
                                    shift_d   = pid_byte(pkt_q);
                                    bit_idx_d = 4'd0;
                                end
                                StPid, StData: begin
                                    if (!is_data) begin
                                        send_se0 = 1'b1;
                                    end else if (buffer_occ != '0 && byte_cnt_d < CntMax) begin
                                        state_d    = StData;
                                        shift_d    = tx_data;
                                        bit_idx_d  = 4'd0;
                                        byte_cnt_d = byte_cnt_d + CntW'(1);
                                        pop_d      = 1'b1;
                                    end else begin
                                        state_d   = StCrcLo;
                                        shift_d   = ~crc[7:0];
                                        bit_idx_d = 4'd0;
                                    end
                                end
                                StCrcLo: begin
                                    state_d   = StCrcHi;
                                    shift_d   = ~crc[15:8];
                                    bit_idx_d = 4'd0;
                                end
                                default: send_se0 = 1'b1;
                            endcase
                        end
                        if (!send_se0) begin
                            tx_bit    = shift_d[0];
                            shift_d   = {1'b0, shift_d[7:1]};
                            bit_idx_d = bit_idx_d + 4'd1;
                            ones_d    = tx_bit ? ones_d + 3'd1 : 3'd0;
                            if (state_d == StData) begin
                                crc_en  = 1'b1;
                                crc_din = tx_bit;
                            end
                        end
                    end

                    if (send_se0) begin
                        state_d   = StEopSe0;
                        bit_idx_d = 4'd1;
                        dp_d      = 1'b0;
                        dm_d      = 1'b0;
                    end else begin
                        if (!tx_bit) begin
                            line_d = ~line_d;
                        end
                        dp_d = line_d;
                        dm_d = ~line_d;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            pkt_q      <= TxNone;
            bit_cnt_q  <= '0;
            shift_q    <= 8'h00;
            bit_idx_q  <= 4'd0;
            ones_q     <= 3'd0;
            byte_cnt_q <= '0;
            line_q     <= 1'b1;
            dp_q       <= 1'b1;
            dm_q       <= 1'b0;
            pop_q      <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pkt_q      <= pkt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            ones_q     <= ones_d;
            byte_cnt_q <= byte_cnt_d;
            line_q     <= line_d;
            dp_q       <= dp_d;
            dm_q       <= dm_d;
            pop_q      <= pop_d;
            active_q   <= active_d;
        end
    end

    assign get_tx_data        = pop_q;
    assign dp_out             = dp_q;
    assign dm_out             = dm_q;
    assign tx_transfer_active = active_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: a packet table plus random packets, each checked cycle by cycle
// against a bit-stream model (field bits, stuffing, NRZI, CRC16 by polynomial long division).
module tb_usb_tx_encoder;

    localparam int CPB  = 4;
    localparam int MAXP = 64;
`ifdef USB_TX_DATA1_EN
    localparam bit Data1En = 1'b1;
`else
    localparam bit Data1En = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic [2:0] tx_packet;
    logic [6:0] buffer_occ;
    logic [7:0] tx_data;
    logic       get_tx_data;
    logic       dp_out;
    logic       dm_out;
    logic       tx_transfer_active;

    usb_tx_encoder #(
        .CLKS_PER_BIT (CPB),
        .MAX_PAYLOAD  (MAXP)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .buffer_occ         (buffer_occ),
        .tx_data            (tx_data),
        .get_tx_data        (get_tx_data),
        .dp_out             (dp_out),
        .dm_out             (dm_out),
        .tx_transfer_active (tx_transfer_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] pkt;
        int         nbytes;
        int         pattern;   // 0: 0x00, 1: 0xFF, 2: random
        int         inject;    // cycle at which a stray request is driven, -1 for none
        int         exp_pops;  // -1: take from the model
        int         exp_left;
        int         exp_active;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] buf_q[$];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic sync_buffer();
        buffer_occ = (buf_q.size() > 127) ? 7'd127 : 7'(buf_q.size());
        tx_data    = (buf_q.size() != 0) ? buf_q[0] : 8'h00;
    endtask

    task automatic add_vec(input string name, input logic [2:0] pkt, input int nbytes,
                           input int pattern, input int inject, input int exp_pops,
                           input int exp_left, input int exp_active);
        vec_t v;
        v.name = name; v.pkt = pkt; v.nbytes = nbytes; v.pattern = pattern; v.inject = inject;
        v.exp_pops = exp_pops; v.exp_left = exp_left; v.exp_active = exp_active;
        vecs.push_back(v);
    endtask

    task automatic fill_buffer(input int nbytes, input int pattern);
        buf_q.delete();
        for (int i = 0; i < nbytes; i++) begin
            case (pattern)
                0:       buf_q.push_back(8'h00);
                1:       buf_q.push_back(8'hFF);
                default: buf_q.push_back(8'($urandom_range(0, 255)));
            endcase
        end
        sync_buffer();
    endtask

    // Remainder of (init * x^len + M(x) * x^16) mod P, first transmitted bit = highest degree.
    function automatic logic [15:0] crc16_ref(input logic [7:0] bytes[$]);
        bit          a[];
        int          len;
        logic [16:0] poly;
        logic [7:0]  b;
        logic [15:0] r;
        poly = 17'h18005;
        len  = bytes.size() * 8;
        a    = new[len + 16];
        for (int i = 0; i < len; i++) begin
            b    = bytes[i / 8];
            a[i] = b[i % 8];
        end
        for (int k = 0; k < 16; k++) a[k] = a[k] ^ 1'b1;
        for (int i = 0; i < len; i++) begin
            if (a[i]) begin
                for (int j = 0; j <= 16; j++) a[i + j] = a[i + j] ^ poly[16 - j];
            end
        end
        for (int k = 0; k < 16; k++) r[15 - k] = a[len + k];
        return r;
    endfunction

    task automatic run_packet(input string name, input logic [2:0] pkt, input int inject,
                              input int tab_pops, input int tab_left, input int tab_active);
        bit          raw[$];
        bit          is_start[$];
        bit          stuffed[$];
        logic [1:0]  line[$];
        int          pop_cyc[$];
        logic [7:0]  pay[$];
        logic [7:0]  pid;
        logic [7:0]  sync_b;
        logic [7:0]  byte_v;
        logic [15:0] crc_tx;
        bit          acc;
        bit          data_pkt;
        bit          lvl;
        int          n, ones, total, pop_idx, act_cnt, pop_cnt, first_bad;
        int          exp_pops, exp_left, exp_active;
        logic [3:0]  got_v, exp_v, bad_got, bad_exp;

        acc      = (pkt >= 3'd1 && pkt <= 3'd4) || (pkt == 3'd5 && Data1En);
        data_pkt = acc && (pkt == 3'd1 || pkt == 3'd5);
        case (pkt)
            3'd1:    pid = 8'hC3;
            3'd2:    pid = 8'hD2;
            3'd3:    pid = 8'h5A;
            3'd4:    pid = 8'h1E;
            default: pid = 8'h4B;
        endcase
        sync_b = 8'h80;
        n = 0;
        if (acc) begin
            for (int k = 0; k < 8; k++) begin raw.push_back(sync_b[k]); is_start.push_back(0); end
            for (int k = 0; k < 8; k++) begin raw.push_back(pid[k]); is_start.push_back(0); end
            if (data_pkt) begin
                n = (buf_q.size() < MAXP) ? buf_q.size() : MAXP;
                for (int j = 0; j < n; j++) pay.push_back(buf_q[j]);
                for (int j = 0; j < n; j++) begin
                    byte_v = pay[j];
                    for (int k = 0; k < 8; k++) begin
                        raw.push_back(byte_v[k]);
                        is_start.push_back(k == 0);
                    end
                end
                crc_tx = ~crc16_ref(pay);
                for (int k = 0; k < 16; k++) begin raw.push_back(crc_tx[k]); is_start.push_back(0); end
            end
            ones = 0;
            for (int i = 0; i < raw.size(); i++) begin
                if (is_start[i]) pop_cyc.push_back(stuffed.size() * CPB);
                stuffed.push_back(raw[i]);
                ones = raw[i] ? ones + 1 : 0;
                if (ones == 6) begin stuffed.push_back(1'b0); ones = 0; end
            end
            lvl = 1'b1;
            foreach (stuffed[i]) begin
                if (!stuffed[i]) lvl = ~lvl;
                line.push_back({lvl, ~lvl});
            end
            line.push_back(2'b00);
            line.push_back(2'b00);
            line.push_back(2'b10);
        end
        total      = line.size() * CPB;
        exp_pops   = (tab_pops >= 0) ? tab_pops : n;
        exp_left   = (tab_left >= 0) ? tab_left : buf_q.size() - n;
        exp_active = (tab_active >= 0) ? tab_active : total;

        @(negedge clk);
        tx_packet = pkt;
        @(negedge clk);
        tx_packet = 3'd0;
        pop_idx = 0; act_cnt = 0; pop_cnt = 0; first_bad = -1;
        bad_got = '0; bad_exp = '0;
        for (int c = 0; c < total + 3 * CPB; c++) begin
            exp_v[3:2] = (c < total) ? line[c / CPB] : 2'b10;
            exp_v[1]   = (c < total);
            exp_v[0]   = (pop_idx < pop_cyc.size()) && (pop_cyc[pop_idx] == c);
            if (exp_v[0]) pop_idx++;
            got_v = {dp_out, dm_out, tx_transfer_active, get_tx_data};
            if (got_v !== exp_v && first_bad < 0) begin
                first_bad = c; bad_got = got_v; bad_exp = exp_v;
            end
            if (tx_transfer_active) act_cnt++;
            if (get_tx_data) begin
                pop_cnt++;
                if (buf_q.size() != 0) void'(buf_q.pop_front());
                sync_buffer();
            end
            if (c == inject) tx_packet = 3'd2;
            else if (c == inject + 1) tx_packet = 3'd0;
            @(negedge clk);
        end
        checks++;
        if (first_bad >= 0) begin
            errors++;
            $display("FAIL %s trace: cycle %0d got dp,dm,active,pop=%b expected %b",
                     name, first_bad, bad_got, bad_exp);
        end
        check({name, " pops"}, pop_cnt, exp_pops);
        check({name, " active cycles"}, act_cnt, exp_active);
        check({name, " bytes left"}, buf_q.size(), exp_left);
    endtask

    initial begin
        n_rst     = 1'b0;
        tx_packet = 3'd0;
        buf_q.delete();
        sync_buffer();

        #12;
        check("reset dp", dp_out, 1);
        check("reset dm", dm_out, 0);
        check("reset active", tx_transfer_active, 0);
        check("reset pop", get_tx_data, 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        add_vec("ack",      3'd2, 0,  0, -1,  0, 0, 76);
        add_vec("nak",      3'd3, 0,  0, -1,  0, 0, 76);
        add_vec("stall",    3'd4, 0,  0, -1,  0, 0, 76);
        add_vec("zlp",      3'd1, 0,  0, -1,  0, 0, 140);
        add_vec("ff2",      3'd1, 2,  1, -1,  2, 0, -1);
        add_vec("zero1",    3'd1, 1,  0, -1,  1, 0, -1);
        add_vec("occ68",    3'd1, 68, 2, -1, 64, 4, -1);
        add_vec("inject",   3'd1, 4,  2, 100, 4, 0, -1);
        add_vec("ack_busy", 3'd2, 3,  2, -1,  0, 3, 76);
        add_vec("illegal6", 3'd6, 2,  2, -1,  0, 2, 0);
        add_vec("illegal7", 3'd7, 0,  0, -1,  0, 0, 0);
        add_vec("data1",    3'd5, 3,  2, -1, Data1En ? 3 : 0, Data1En ? 0 : 3, -1);

        foreach (vecs[i]) begin
            fill_buffer(vecs[i].nbytes, vecs[i].pattern);
            run_packet(vecs[i].name, vecs[i].pkt, vecs[i].inject,
                       vecs[i].exp_pops, vecs[i].exp_left, vecs[i].exp_active);
        end

        for (int i = 0; i < 8; i++) begin
            fill_buffer($urandom_range(0, 70), 2);
            run_packet($sformatf("rand%0d", i), 3'($urandom_range(1, 4)), -1, -1, -1, -1);
        end

        // Asynchronous reset in the middle of the payload.
        fill_buffer(10, 2);
        @(negedge clk);
        tx_packet = 3'd1;
        @(negedge clk);
        tx_packet = 3'd0;
        repeat (25 * CPB) @(negedge clk);
        check("midpkt active", tx_transfer_active, 1);
        #1 n_rst = 1'b0;
        #1;
        check("abort dp", dp_out, 1);
        check("abort dm", dm_out, 0);
        check("abort active", tx_transfer_active, 0);
        check("abort pop", get_tx_data, 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post-abort idle", {dp_out, dm_out, tx_transfer_active}, 3'b100);
        buf_q.delete();
        sync_buffer();
        run_packet("ack_after_abort", 3'd2, -1, 0, 0, 76);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
USB full-speed transmit encoder. It sits directly downstream of data_buffer and consumes its 8-bit tx_data_out through the get_tx_data pop strobe. For each handshake or DATA packet requested on tx_packet, it serialises SYNC, PID, payload and CRC16, then EOP onto the D+/D- pins. Bit stuffing and NRZI coding are applied.

Parameters:
CLKS_PER_BIT, 4, clk cycles per USB bit (48 MHz clk / 12 Mbps)
MAX_PAYLOAD, 64, max data bytes per DATA packet

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
tx_packet  input  3  request: 0 none, 1 DATA0, 2 ACK, 3 NAK, 4 STALL, 5 DATA1 (feature-gated)
buffer_occ  input  7  byte count from data_buffer
tx_data  input  8  byte at data_buffer read pointer (combinational from buffer)
get_tx_data  output  1  one-cycle pop strobe to data_buffer
dp_out  output  1  D+ drive
dm_out  output  1  D- drive
tx_transfer_active  output  1  high from accept until end of EOP

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Reset values: dp_out=1, dm_out=0 (J/idle), get_tx_data=0, tx_transfer_active=0. FSM returns to IDLE.
- All outputs are registered.
- FSM states: IDLE -> SYNC -> PID -> DATA -> CRC_LO -> CRC_HI -> EOP_SE0 -> EOP_J -> IDLE. Handshake PIDs go PID -> EOP_SE0 directly.
- Accept:
  - In IDLE, a non-zero legal tx_packet is latched on the clock edge. tx_transfer_active rises the same edge.
  - tx_packet is ignored while not in IDLE. Illegal codes are ignored.
- Bit timing:
  - A bit counter 0..CLKS_PER_BIT-1 runs from accept.
  - Each line bit is held for exactly CLKS_PER_BIT cycles.
  - The first SYNC bit appears on dp/dm the cycle after accept.
- Bit order is LSB first for every byte.
- SYNC is 8'h80 as transmitted (seven 0s, then 1).
- PID byte is {~pid4, pid4}: DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
- DATA state:
  - At each byte boundary (end of the PID or end of a data byte), if buffer_occ != 0 and the sent count < MAX_PAYLOAD: load tx_data into the shift register and pulse get_tx_data for that one cycle.
  - Otherwise go to CRC_LO.
  - buffer_occ=0 at the PID boundary gives a zero-length packet.
- CRC16:
  - Polynomial 0x8005, init 0xFFFF, computed over payload data bits only (pre-stuff).
  - The transmitted value is ~crc, LSB first. ZLP therefore sends 16 zeros.
- Bit stuffing:
  - The ones counter resets at SYNC start.
  - After six consecutive 1 bits (pre-NRZI) a 0 is inserted. The insert takes one bit time, and the shifter stalls during it.
  - Stuffing applies to SYNC, PID, data and CRC. A stuff due after the last CRC bit is sent before EOP.
- NRZI:
  - A 0 toggles the line, a 1 holds it.
  - The line state starts at J (dp=1, dm=0). K is dp=0, dm=1.
- EOP: SE0 (dp=0, dm=0) for 2 bit times, then J for 1 bit time. tx_transfer_active falls on the edge entering IDLE.
- Payload limit: if buffer_occ exceeds MAX_PAYLOAD, exactly MAX_PAYLOAD bytes are sent and the remainder stays in the buffer.
- Reset mid-packet aborts immediately to J/IDLE. No partial EOP is sent.

Optional Feature:
- Macro: USB_TX_DATA1_EN.
- Defined: tx_packet=5 sends a DATA1 packet (PID 0x4B) with payload/CRC behaviour identical to DATA0.
- Undefined: code 5 is illegal and ignored in IDLE. No DATA1 logic is synthesised.

Decomposition:
- Package usb_pkg holds:
  - tx_packet_t enum
  - PID constants (PID_DATA0, PID_DATA1, PID_ACK, PID_NAK, PID_STALL)
  - SYNC_BYTE, CRC16_POLY, CRC16_INIT
  - tx_state_t enum
- Sub-module usb_crc16: serial bit-in CRC with clear, enable and din inputs and a 16-bit crc output. It is reusable by the future RX checker.

Test Plan:
- ACK after reset: tx_packet=2 for one cycle -> line K,J,K,J,K,J,K,K then PID 0xD2 NRZI, SE0 8 cycles, J 4 cycles. tx_transfer_active high 76 cycles. No get_tx_data.
- DATA0 ZLP, buffer_occ=0: -> PID 0xC3, 16 CRC zero bits (16 toggles), EOP. get_tx_data never pulses.
- DATA0 with 2 bytes 0xFF,0xFF:
  - Exactly 2 get_tx_data pulses, each one cycle wide, at the byte boundaries.
  - Stuffed 0 after every six 1s; line toggles at those points.
  - Total bit count includes the stuffs.
- DATA0 with 1 byte 0x00 -> payload 8 toggles, CRC field = ~CRC16(0x00) LSB first. Bench reference model compares.
- Limits and boundaries:
  - buffer_occ=68 -> exactly 64 pops.
  - tx_packet asserted mid-packet -> ignored.
  - n_rst low during DATA -> dp=1, dm=0, active=0 asynchronously.
- tx_packet=5 -> DATA1 PID 0x4B with USB_TX_DATA1_EN defined. With the macro undefined -> no transfer.
